// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared types, constants and helpers for the instruction
//                fetch stage (fetch_unit and its fetch_fifo).
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_unit_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0) presented when no word is buffered
    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FLUSH  = 2'd2
    } fetch_state_t;

    // One buffered fetch result; pc sits in the upper half
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

    // Force an address onto a 32-bit word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous FIFO holding {pc, ir} fetch results.
//                Head entry is visible without a pop (show-ahead), flush
//                empties it in one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage array: written on push, no reset needed for data
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush discards every entry at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Issues in-order word reads, buffers
//                returned words with their pc, and presents them to the
//                decoder. Handles redirect (branch/jump) and halt.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  r_state;
    logic [31:0]   r_fetch_addr;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_in_flight;
    logic [CW-1:0] r_drop_cnt;

    logic [CW-1:0] w_drop_next;
    logic [CW:0]   w_credit_used;
    logic          w_credit_ok;
    logic          w_accept;
    logic          w_dropping;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    // Credits cover both buffered words and words still in memory, so a
    // returning response always finds a free FIFO slot.
    assign w_credit_used = {1'b0, r_in_flight} + {1'b0, w_fifo_count};
    assign w_credit_ok   = (w_credit_used < (CW + 1)'(DEPTH));

    // rst gates the request so the port reads idle the moment reset asserts
    assign imem_req  = ~rst & (r_state != ST_HALTED) & ~redirect & w_credit_ok;
    assign imem_addr = r_fetch_addr;
    assign w_accept  = imem_req & imem_ready;

    // Responses to requests issued before a redirect are stale and discarded
    assign w_dropping   = (r_drop_cnt != '0);
    assign w_push       = imem_rvalid & ~redirect & ~w_dropping & ~w_fifo_full;
    assign w_push_entry = '{pc: r_resp_pc, ir: imem_rdata};

    assign ir_valid = ~w_fifo_empty & ~redirect;
    assign w_pop    = ir_valid & ir_ready;
    assign ir       = w_fifo_empty ? NOP_INSN : w_head.ir;
    assign pc       = w_fifo_empty ? 32'h0    : w_head.pc;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head_data (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // Next drop count: a redirect marks everything still outstanding as stale
    always_comb begin
        w_drop_next = r_drop_cnt;
        if (redirect) begin
            w_drop_next = r_in_flight - (imem_rvalid ? CW'(1) : CW'(0));
        end else if (imem_rvalid && w_dropping) begin
            w_drop_next = r_drop_cnt - 1'b1;
        end
    end

    // Outstanding-request and stale-response counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_flight <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_drop_cnt <= w_drop_next;
            if (w_accept && !imem_rvalid) begin
                r_in_flight <= r_in_flight + 1'b1;
            end else if (!w_accept && imem_rvalid) begin
                r_in_flight <= r_in_flight - 1'b1;
            end
        end
    end

    // Request address and the pc tagged onto the next kept response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_addr <= RESET_PC;
            r_resp_pc    <= RESET_PC;
        end else if (redirect) begin
            r_fetch_addr <= word_align(redirect_pc);
            r_resp_pc    <= word_align(redirect_pc);
        end else begin
            if (w_accept) begin
                r_fetch_addr <= r_fetch_addr + 32'd4;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
        end
    end

    // Control FSM: redirect wins over halt and over flush completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else if (redirect) begin
            r_state <= (r_in_flight != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (halt) begin
                        r_state <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                ST_FLUSH: begin
                    if (w_drop_next == '0) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit, with a small
//                1/2-cycle-latency instruction memory model and a second
//                instance exercising address wrap from a high RESET_PC.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;

    // wrap instance
    logic        wr_req;
    logic [31:0] wr_addr;
    logic        wr_rvalid;
    logic [31:0] wr_rdata;
    logic [31:0] wr_ir;
    logic [31:0] wr_pc;
    logic        wr_ir_valid;
    logic        one  = 1'b1;
    logic        zero = 1'b0;
    logic [31:0] zero32 = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;
    int mem_lat = 1;

    logic [31:0] acc_q[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_ir[$];
    logic [31:0] wr_acc_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir(ir), .pc(pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(wr_req), .imem_addr(wr_addr), .imem_ready(one),
        .imem_rvalid(wr_rvalid), .imem_rdata(wr_rdata),
        .ir(wr_ir), .pc(wr_pc), .ir_valid(wr_ir_valid), .ir_ready(one),
        .redirect(zero), .redirect_pc(zero32), .halt(zero)
    );

    // memory model for main DUT: in-order pipeline, latency 1 or 2
    logic [1:0]  mv;
    logic [31:0] ma0, ma1;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mv <= 2'b00;
        end else begin
            mv[0] <= imem_req & imem_ready;
            ma0   <= imem_addr;
            mv[1] <= mv[0];
            ma1   <= ma0;
        end
    end
    assign imem_rvalid = (mem_lat == 2) ? mv[1] : mv[0];
    assign imem_rdata  = word_of((mem_lat == 2) ? ma1 : ma0);

    // memory model for wrap instance: latency 1
    logic        wv;
    logic [31:0] wa;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wv <= 1'b0;
        end else begin
            wv <= wr_req;
            wa <= wr_addr;
        end
    end
    assign wr_rvalid = wv;
    assign wr_rdata  = word_of(wa);

    // monitor: log accepted addresses and delivered instructions
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req && imem_ready) acc_q.push_back(imem_addr);
            if (ir_valid && ir_ready) begin
                del_pc.push_back(pc);
                del_ir.push_back(ir);
            end
            if (wr_req) wr_acc_q.push_back(wr_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // reset both DUTs and the memory, then release just after a rising edge
    task automatic start(input int lat, input logic rdy, input logic irr);
        rst = 1'b1;
        mem_lat = lat;
        imem_ready = rdy;
        ir_ready = irr;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        halt = 1'b0;
        @(posedge clk);
        #2;
        acc_q.delete();
        del_pc.delete();
        del_ir.delete();
        wr_acc_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // ---------------- reset values ----------------
        rst = 1'b1;
        imem_ready = 1'b1;
        ir_ready = 1'b1;
        cyc(2);
        check("rst_req",      {31'd0, imem_req}, 32'd0);
        check("rst_addr",     imem_addr, 32'h0);
        check("rst_ir",       ir, 32'h0000_0013);
        check("rst_pc",       pc, 32'h0);
        check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("rst_wrap_addr", wr_addr, 32'hFFFF_FFF8);

        // ---------------- stream ----------------
        start(1, 1'b1, 1'b1);
        @(negedge clk);
        check("str_req0",  {31'd0, imem_req}, 32'd1);
        check("str_addr0", imem_addr, 32'h0);
        @(negedge clk);
        check("str_valid_lat1", {31'd0, ir_valid}, 32'd0);
        @(negedge clk);
        check("str_valid_lat2", {31'd0, ir_valid}, 32'd1);
        check("str_pc_first",   pc, 32'h0);
        check("str_ir_first",   ir, word_of(32'h0));
        cyc(20);
        check("str_n_del", {31'd0, del_pc.size() >= 6}, 32'd1);
        check("str_n_acc", {31'd0, acc_q.size() >= 6}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("str_del_pc%0d", i), del_pc[i], 32'(i * 4));
            check($sformatf("str_del_ir%0d", i), del_ir[i], word_of(32'(i * 4)));
            check($sformatf("str_acc%0d", i), acc_q[i], 32'(i * 4));
        end
        check("wrap_n_acc", {31'd0, wr_acc_q.size() >= 3}, 32'd1);
        check("wrap_acc0", wr_acc_q[0], 32'hFFFF_FFF8);
        check("wrap_acc1", wr_acc_q[1], 32'hFFFF_FFFC);
        check("wrap_acc2", wr_acc_q[2], 32'h0000_0000);

        // ---------------- async reset mid-burst ----------------
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_req",      {31'd0, imem_req}, 32'd0);
        check("arst_addr",     imem_addr, 32'h0);
        check("arst_ir",       ir, 32'h0000_0013);
        check("arst_pc",       pc, 32'h0);
        check("arst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("arst_wrap_addr", wr_addr, 32'hFFFF_FFF8);

        // ---------------- backpressure ----------------
        start(1, 1'b1, 1'b0);
        cyc(10);
        check("bp_n_acc",   acc_q.size(), 32'd2);
        check("bp_req",     {31'd0, imem_req}, 32'd0);
        check("bp_valid",   {31'd0, ir_valid}, 32'd1);
        check("bp_pc_head", pc, 32'h0);
        ir_ready = 1'b1;
        cyc(8);
        check("bp_n_del", {31'd0, del_pc.size() >= 3}, 32'd1);
        check("bp_del0", del_pc[0], 32'h0);
        check("bp_del1", del_pc[1], 32'h4);
        check("bp_del2", del_pc[2], 32'h8);

        // ---------------- redirect while head is valid ----------------
        start(1, 1'b1, 1'b0);
        cyc(6);
        ir_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        check("rdv_valid_gated", {31'd0, ir_valid}, 32'd0);
        check("rdv_req_gated",   {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #2;
        redirect = 1'b0;
        check("rdv_no_xfer", del_pc.size(), 32'd0);
        cyc(6);
        check("rdv_n_del", {31'd0, del_pc.size() >= 1}, 32'd1);
        check("rdv_del0", del_pc[0], 32'h0000_0200);

        // ---------------- memory stall ----------------
        start(1, 1'b1, 1'b1);
        k = 0;
        while (acc_q.size() < 2 && k < 10) begin
            cyc(1);
            k++;
        end
        check("stl_pre_acc", {31'd0, acc_q.size() >= 2}, 32'd1);
        imem_ready = 1'b0;
        k = 0;
        @(negedge clk);
        while (!imem_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("stl_req%0d", i),  {31'd0, imem_req}, 32'd1);
            check($sformatf("stl_addr%0d", i), imem_addr, 32'h8);
        end
        @(posedge clk);
        #2;
        imem_ready = 1'b1;
        @(negedge clk);
        check("stl_acc_req",  {31'd0, imem_req}, 32'd1);
        check("stl_acc_addr", imem_addr, 32'h8);
        cyc(10);
        check("stl_n_acc", {31'd0, acc_q.size() >= 4}, 32'd1);
        check("stl_acc2", acc_q[2], 32'h8);
        check("stl_acc3", acc_q[3], 32'hC);
        check("stl_n_del", {31'd0, del_pc.size() >= 4}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stl_del%0d", i), del_pc[i], 32'(i * 4));
        end

        // ---------------- redirect with 2 in flight ----------------
        start(2, 1'b1, 1'b1);
        k = 0;
        while (acc_q.size() < 2 && k < 10) begin
            cyc(1);
            k++;
        end
        check("rd2_pre_acc", acc_q.size(), 32'd2);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        acc_q.delete();
        del_pc.delete();
        del_ir.delete();
        @(negedge clk);
        check("rd2_valid_gated", {31'd0, ir_valid}, 32'd0);
        check("rd2_req_gated",   {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #2;
        redirect = 1'b0;
        @(negedge clk);
        check("rd2_req_next",  {31'd0, imem_req}, 32'd1);
        check("rd2_addr_next", imem_addr, 32'h0000_0100);
        cyc(12);
        check("rd2_n_del", {31'd0, del_pc.size() >= 2}, 32'd1);
        check("rd2_del0",    del_pc[0], 32'h0000_0100);
        check("rd2_del0_ir", del_ir[0], word_of(32'h0000_0100));
        check("rd2_del1",    del_pc[1], 32'h0000_0104);
        check("rd2_acc0",    acc_q[0], 32'h0000_0100);

        // ---------------- halt with 1 in flight ----------------
        start(1, 1'b1, 1'b1);
        halt = 1'b1;
        @(posedge clk);
        #2;
        halt = 1'b0;
        cyc(10);
        check("hlt_n_acc", acc_q.size(), 32'd1);
        check("hlt_n_del", del_pc.size(), 32'd1);
        check("hlt_del0",  del_pc[0], 32'h0);
        check("hlt_req",   {31'd0, imem_req}, 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0040;
        @(posedge clk);
        #2;
        redirect = 1'b0;
        @(negedge clk);
        check("hlt_resume_req",  {31'd0, imem_req}, 32'd1);
        check("hlt_resume_addr", imem_addr, 32'h0000_0040);
        cyc(6);
        check("hlt_n_del2", {31'd0, del_pc.size() >= 2}, 32'd1);
        check("hlt_del1",   del_pc[1], 32'h0000_0040);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
